// File: rtl/rf_param.sv
// rf_param -- parametrised register file: two registered read ports and one
// write port. After reset it clears itself to zero and then raises rdy. When
// built with RF_DUMP_EN defined, a halt request streams every entry out on
// the dump port. Without RF_DUMP_EN, hlt is ignored and the dump outputs are
// tied to zero.
//
// All state changes on the falling edge of clk. rst_n is an asynchronous,
// active-low reset.
//
// Parameters:
//   DATA_W   register width
//   ADDR_W   address width, N = 2**ADDR_W registers
//   ZERO_REG 1: register 0 reads as zero and ignores writes
//
// Ports:
//   clk, rst_n              clock (falling-edge active), async reset
//   p0_addr/p1_addr, re0/re1 read addresses and capture enables
//   dst_addr, dst, we       write port
//   hlt                     halt request (starts a dump)
//   p0, p1                  read data (registered, with write bypass)
//   rdy                     clear sequence finished
//   dump_vld/addr/data      one entry per cycle while dumping
//   dump_done               dump finished; held while halted
//
// State | meaning
// INIT    | clearing entry[clr_cnt], file not yet usable
// RUN     | normal read/write operation
// DUMP    | streaming entry[dump_idx] out, writes blocked (RF_DUMP_EN only)
// HALTED  | dump complete, waiting for hlt to drop (RF_DUMP_EN only)
module rf_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              re0,
  input  logic              re1,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [DATA_W-1:0] dst,
  input  logic              we,
  input  logic              hlt,
  output logic [DATA_W-1:0] p0,
  output logic [DATA_W-1:0] p1,
  output logic              rdy,
  output logic              dump_vld,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  localparam int N = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

`ifdef RF_DUMP_EN
  typedef enum logic [1:0] {S_INIT, S_RUN, S_DUMP, S_HALTED} state_t;
`else
  typedef enum logic {S_INIT, S_RUN} state_t;
`endif

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
  logic                rdy_q, rdy_nxt;
  logic [DATA_W-1:0]   rd0_q, rd1_q;
  logic [DATA_W-1:0]   mem [N];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                rd_en;
  logic                zero_wr;

  assign zero_wr = (ZERO_REG != 0) && (dst_addr == '0);

`ifdef RF_DUMP_EN
  // Extra index bit marks "all N entries presented" so the move to HALTED
  // (and the rise of dump_done) lands one edge after the last entry.
  logic [ADDR_W:0]     dump_idx, dump_idx_nxt;
  logic                dvld_q, dvld_nxt;
  logic [ADDR_W-1:0]   daddr_q, daddr_nxt;
  logic [DATA_W-1:0]   ddata_q, ddata_nxt;
  logic                ddone_q, ddone_nxt;
`endif

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    rdy_nxt     = rdy_q;
    mem_we      = 1'b0;
    mem_waddr   = dst_addr;
    mem_wdata   = dst;
    rd_en       = 1'b0;
`ifdef RF_DUMP_EN
    dump_idx_nxt = dump_idx;
    dvld_nxt     = 1'b0;
    daddr_nxt    = daddr_q;
    ddata_nxt    = ddata_q;
    ddone_nxt    = ddone_q;
`endif
    case (state)
      S_INIT: begin
        mem_we      = 1'b1;
        mem_waddr   = clr_cnt;
        mem_wdata   = '0;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST_IDX) begin
          state_nxt = S_RUN;
          rdy_nxt   = 1'b1;
        end
      end
      S_RUN: begin
        rd_en  = 1'b1;
        mem_we = we && !zero_wr;
`ifdef RF_DUMP_EN
        if (hlt) begin
          state_nxt    = S_DUMP;
          dump_idx_nxt = '0;
        end
`endif
      end
`ifdef RF_DUMP_EN
      S_DUMP: begin
        rd_en = 1'b1;
        if (!dump_idx[ADDR_W]) begin
          dvld_nxt     = 1'b1;
          daddr_nxt    = dump_idx[ADDR_W-1:0];
          ddata_nxt    = ((ZERO_REG != 0) && (dump_idx[ADDR_W-1:0] == '0))
                         ? '0 : mem[dump_idx[ADDR_W-1:0]];
          dump_idx_nxt = dump_idx + 1'b1;
        end else begin
          state_nxt = S_HALTED;
          ddone_nxt = 1'b1;
        end
      end
      S_HALTED: begin
        rd_en     = 1'b1;
        ddone_nxt = 1'b1;
        if (!hlt) begin
          state_nxt = S_RUN;
          ddone_nxt = 1'b0;
        end
      end
`endif
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_INIT;
      clr_cnt <= '0;
      rdy_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      rdy_q   <= rdy_nxt;
      if (rd_en && re0) rd0_q <= mem[p0_addr];
      if (rd_en && re1) rd1_q <= mem[p1_addr];
    end
  end

`ifdef RF_DUMP_EN
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_idx <= '0;
      dvld_q   <= 1'b0;
      daddr_q  <= '0;
      ddata_q  <= '0;
      ddone_q  <= 1'b0;
    end else begin
      dump_idx <= dump_idx_nxt;
      dvld_q   <= dvld_nxt;
      daddr_q  <= daddr_nxt;
      ddata_q  <= ddata_nxt;
      ddone_q  <= ddone_nxt;
    end
  end

  assign dump_vld  = dvld_q;
  assign dump_addr = daddr_q;
  assign dump_data = ddata_q;
  assign dump_done = ddone_q;
`else
  logic unused_hlt;
  assign unused_hlt = hlt;
  assign dump_vld   = 1'b0;
  assign dump_addr  = '0;
  assign dump_data  = '0;
  assign dump_done  = 1'b0;
`endif

  // Storage has no reset; the INIT sequence clears it.
  always_ff @(negedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Zero-register rule wins over the bypass; bypass only exists in RUN.
  always_comb begin
    if ((ZERO_REG != 0) && (p0_addr == '0))
      p0 = '0;
    else if (we && (state == S_RUN) && (dst_addr == p0_addr))
      p0 = dst;
    else
      p0 = rd0_q;

    if ((ZERO_REG != 0) && (p1_addr == '0))
      p1 = '0;
    else if (we && (state == S_RUN) && (dst_addr == p1_addr))
      p1 = dst;
    else
      p1 = rd1_q;
  end

  assign rdy = rdy_q;

endmodule
